// File: rtl/pd_tx_retry_engine.sv
`default_nettype none
// pd_tx_retry_engine: USB-PD transmit controller that frames a request for the PHY,
// waits for a matching GoodCRC under a timeout and retries up to nRetryCount times.
module pd_tx_retry_engine #(
  parameter int N_DO        = 7,
  parameter int CRC_TIMEOUT = 3,
  parameter int RC_W        = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   TRANSMIT_VALID,
  input  logic [15:0]            TRANSMIT,
  input  logic [7:0]             TRANSMIT_HEADER_LOW,
  input  logic [7:0]             TRANSMIT_HEADER_HIGH,
  input  logic [32*N_DO-1:0]     TRANSMIT_DATA_OBJECTS,
  input  logic [RC_W-1:0]        nRetryCount,
  input  logic                   TX_ENABLE,
  input  logic                   MessageSentToPhy,
  input  logic                   GoodCRCResponse,
  input  logic [2:0]             RX_GOODCRC_MSG_ID,
  input  logic [2:0]             RX_BUF_FRAME_TYPE,
  input  logic                   RxMessageDiscard,
  output logic                   TX_REQUEST,
  output logic [16+32*N_DO-1:0]  TRANSMIT_DATA_OUTPUT,
  output logic                   TX_BUSY,
  output logic                   Alert_MessageSuccessful,
  output logic                   Alert_MessageFailed,
  output logic                   Alert_MessageDiscarded
);

  localparam int FW = 16 + 32 * N_DO;
  localparam int TW = (CRC_TIMEOUT > 1) ? $clog2(CRC_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_LOAD        = 4'd1,
    S_SEND        = 4'd2,
    S_WAIT_CRC    = 4'd3,
    S_MATCH       = 4'd4,
    S_CHECK_RETRY = 4'd5,
    S_SUCCESS     = 4'd6,
    S_FAIL        = 4'd7,
    S_DISCARD     = 4'd8
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      sop, msg_id;
  logic [FW-1:0]   frame;
  logic [RC_W-1:0] retry_cnt, cnt_inc;
  logic [TW-1:0]   timer;
  logic            accept, hard_reset, discard;
  logic            unused_bits;

  assign unused_bits = ^TRANSMIT[15:3];
  assign accept      = TRANSMIT_VALID && (TRANSMIT[2:0] <= 3'd5);
  assign hard_reset  = (sop == 3'd5);
  // Hard reset has no GoodCRC handshake, so an incoming message cannot cancel it.
  assign discard     = RxMessageDiscard && !hard_reset;
  assign cnt_inc     = (retry_cnt == {RC_W{1'b1}}) ? retry_cnt : retry_cnt + 1'b1;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:        if (accept) state_nx = S_LOAD;
      S_LOAD:        state_nx = S_SEND;
      S_SEND: begin
        if (discard)               state_nx = S_DISCARD;
        else if (MessageSentToPhy) state_nx = hard_reset ? S_SUCCESS : S_WAIT_CRC;
      end
      S_WAIT_CRC: begin
        if (discard)                              state_nx = S_DISCARD;
        else if (GoodCRCResponse)                 state_nx = S_MATCH;
        else if (timer == TW'(CRC_TIMEOUT - 1))   state_nx = S_CHECK_RETRY;
      end
      S_MATCH: begin
        if (RX_GOODCRC_MSG_ID == msg_id && RX_BUF_FRAME_TYPE == sop) state_nx = S_SUCCESS;
        else                                                          state_nx = S_CHECK_RETRY;
      end
      S_CHECK_RETRY: begin
        if (discard)                    state_nx = S_DISCARD;
        else if (!TX_ENABLE)            state_nx = S_FAIL;
        else if (cnt_inc > nRetryCount) state_nx = S_FAIL;
        else                            state_nx = S_LOAD;
      end
      S_SUCCESS, S_FAIL, S_DISCARD: state_nx = S_IDLE;
      default:                      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state                   <= S_IDLE;
      sop                     <= 3'd0;
      msg_id                  <= 3'd0;
      frame                   <= '0;
      retry_cnt               <= '0;
      timer                   <= '0;
      TX_REQUEST              <= 1'b0;
      TX_BUSY                 <= 1'b0;
      TRANSMIT_DATA_OUTPUT    <= '0;
      Alert_MessageSuccessful <= 1'b0;
      Alert_MessageFailed     <= 1'b0;
      Alert_MessageDiscarded  <= 1'b0;
    end else begin
      state <= state_nx;
      // Outputs are decoded from the next state so they line up with the state register.
      TX_REQUEST              <= (state_nx == S_SEND);
      TX_BUSY                 <= (state_nx != S_IDLE);
      Alert_MessageSuccessful <= (state_nx == S_SUCCESS);
      Alert_MessageFailed     <= (state_nx == S_FAIL);
      Alert_MessageDiscarded  <= (state_nx == S_DISCARD);

      if (state == S_IDLE && accept) begin
        sop       <= TRANSMIT[2:0];
        msg_id    <= TRANSMIT_HEADER_HIGH[3:1];
        frame     <= {TRANSMIT_HEADER_HIGH, TRANSMIT_HEADER_LOW, TRANSMIT_DATA_OBJECTS};
        retry_cnt <= '0;
      end

      if (state == S_LOAD) TRANSMIT_DATA_OUTPUT <= frame;

      if (state == S_SEND)          timer <= '0;
      else if (state == S_WAIT_CRC) timer <= timer + 1'b1;

      if (state == S_CHECK_RETRY && TX_ENABLE && !discard) retry_cnt <= cnt_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pd_tx_retry_engine.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for pd_tx_retry_engine: expected alerts and attempt counts are queued
// per request and checked by a monitor when an alert pulse appears.
module tb_pd_tx_retry_engine;
  localparam int N_DO = 7;
  localparam int CT   = 3;
  localparam int RC_W = 3;
  localparam int FW   = 16 + 32 * N_DO;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              TRANSMIT_VALID = 1'b0;
  logic [15:0]       TRANSMIT = '0;
  logic [7:0]        TRANSMIT_HEADER_LOW = '0;
  logic [7:0]        TRANSMIT_HEADER_HIGH = '0;
  logic [32*N_DO-1:0] TRANSMIT_DATA_OBJECTS = '0;
  logic [RC_W-1:0]   nRetryCount = '0;
  logic              TX_ENABLE = 1'b1;
  logic              MessageSentToPhy = 1'b0;
  logic              GoodCRCResponse = 1'b0;
  logic [2:0]        RX_GOODCRC_MSG_ID = '0;
  logic [2:0]        RX_BUF_FRAME_TYPE = '0;
  logic              RxMessageDiscard = 1'b0;
  logic              TX_REQUEST;
  logic [FW-1:0]     TRANSMIT_DATA_OUTPUT;
  logic              TX_BUSY;
  logic              Alert_MessageSuccessful;
  logic              Alert_MessageFailed;
  logic              Alert_MessageDiscarded;

  pd_tx_retry_engine #(.N_DO(N_DO), .CRC_TIMEOUT(CT), .RC_W(RC_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .TRANSMIT_VALID(TRANSMIT_VALID), .TRANSMIT(TRANSMIT),
    .TRANSMIT_HEADER_LOW(TRANSMIT_HEADER_LOW), .TRANSMIT_HEADER_HIGH(TRANSMIT_HEADER_HIGH),
    .TRANSMIT_DATA_OBJECTS(TRANSMIT_DATA_OBJECTS), .nRetryCount(nRetryCount),
    .TX_ENABLE(TX_ENABLE), .MessageSentToPhy(MessageSentToPhy),
    .GoodCRCResponse(GoodCRCResponse), .RX_GOODCRC_MSG_ID(RX_GOODCRC_MSG_ID),
    .RX_BUF_FRAME_TYPE(RX_BUF_FRAME_TYPE), .RxMessageDiscard(RxMessageDiscard),
    .TX_REQUEST(TX_REQUEST), .TRANSMIT_DATA_OUTPUT(TRANSMIT_DATA_OUTPUT),
    .TX_BUSY(TX_BUSY), .Alert_MessageSuccessful(Alert_MessageSuccessful),
    .Alert_MessageFailed(Alert_MessageFailed), .Alert_MessageDiscarded(Alert_MessageDiscarded)
  );

  always #5 Clock = ~Clock;

  // code: 1 success, 2 failed, 3 discarded; sends = number of SEND phases
  typedef struct { int code; int sends; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   sends = 0;
  int   mon_code;
  logic prev_req = 1'b0;
  logic prev_alert = 1'b0;
  logic [2:0] al;
  logic [FW-1:0] fr, fr2;

  always @(negedge Clock) begin
    al = {Alert_MessageDiscarded, Alert_MessageFailed, Alert_MessageSuccessful};
    if (Reset) begin
      sends = 0; prev_req = 1'b0; prev_alert = 1'b0;
    end else begin
      if (TX_REQUEST && !prev_req) sends++;
      prev_req = TX_REQUEST;
      if (prev_alert) begin
        checks++;
        if (al !== 3'b000) $display("FAIL alert_width: alerts=%b one cycle after pulse, required 000", al);
        else passes++;
      end
      if (al !== 3'b000) begin
        checks++;
        mon_code = (al == 3'b001) ? 1 : (al == 3'b010) ? 2 : (al == 3'b100) ? 3 : 0;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_alert: alerts=%b, required none", al);
        end else begin
          mon_e = sb.pop_front();
          if (mon_code != mon_e.code || sends != mon_e.sends)
            $display("FAIL scoreboard_alert: code=%0d sends=%0d, required code=%0d sends=%0d",
                     mon_code, sends, mon_e.code, mon_e.sends);
          else passes++;
        end
        sends = 0;
      end
      prev_alert = |al;
    end
  end

  task automatic tick;
    @(posedge Clock); #1;
  endtask

  task automatic send_req(input logic [2:0] sop, input logic [2:0] id, output logic [FW-1:0] f);
    logic [7:0] lo, hi;
    lo = 8'($urandom);
    hi = 8'($urandom);
    hi[3:1] = id;
    for (int i = 0; i < N_DO; i++) TRANSMIT_DATA_OBJECTS[32*i +: 32] = $urandom;
    TRANSMIT_HEADER_LOW  = lo;
    TRANSMIT_HEADER_HIGH = hi;
    TRANSMIT = {13'($urandom), sop};
    f = {hi, lo, TRANSMIT_DATA_OBJECTS};
    TRANSMIT_VALID = 1'b1;
    tick;
    TRANSMIT_VALID = 1'b0;
  endtask

  task automatic phy_send;
    int n = 0;
    while (!TX_REQUEST && n < 20) begin tick; n++; end
    checks++;
    if (TX_REQUEST !== 1'b1) $display("FAIL phy_wait_req: TX_REQUEST=%b, required 1 within 20 cycles", TX_REQUEST);
    else passes++;
    MessageSentToPhy = 1'b1;
    tick;
    MessageSentToPhy = 1'b0;
  endtask

  task automatic wait_gap(input bit to_fail, input int expected, input string name);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < 20) begin
      tick; n++;
      hit = to_fail ? Alert_MessageFailed : TX_REQUEST;
    end
    checks++;
    if (hit !== 1'b1 || n != expected)
      $display("FAIL %s: gap=%0d cycles (seen=%b), required %0d", name, n, hit, expected);
    else passes++;
  endtask

  task automatic test_reset;
    Reset = 1'b1; tick; tick;
    checks++;
    if ({TX_REQUEST, TX_BUSY} !== 2'b00) $display("FAIL reset_req_busy: %b, required 00", {TX_REQUEST, TX_BUSY});
    else passes++;
    checks++;
    if ({Alert_MessageSuccessful, Alert_MessageFailed, Alert_MessageDiscarded} !== 3'b000)
      $display("FAIL reset_alerts: %b, required 000",
               {Alert_MessageSuccessful, Alert_MessageFailed, Alert_MessageDiscarded});
    else passes++;
    checks++;
    if (TRANSMIT_DATA_OUTPUT !== '0) $display("FAIL reset_data: %h, required 0", TRANSMIT_DATA_OUTPUT);
    else passes++;
    Reset = 1'b0; tick;
  endtask

  task automatic test_success;
    nRetryCount = '0;
    sb.push_back('{1, 1});
    send_req(3'd0, 3'd3, fr);
    checks++;
    if ({TX_BUSY, TX_REQUEST} !== 2'b10) $display("FAIL load_state: busy/req=%b, required 10", {TX_BUSY, TX_REQUEST});
    else passes++;
    phy_send;
    checks++;
    if (TRANSMIT_DATA_OUTPUT !== fr || TX_REQUEST !== 1'b0)
      $display("FAIL frame_out: data=%h req=%b, required data=%h req=0", TRANSMIT_DATA_OUTPUT, TX_REQUEST, fr);
    else passes++;
    tick;
    GoodCRCResponse = 1'b1; RX_GOODCRC_MSG_ID = 3'd3; RX_BUF_FRAME_TYPE = 3'd0;
    tick;
    GoodCRCResponse = 1'b0;
    tick;
    checks++;
    if (Alert_MessageSuccessful !== 1'b1) $display("FAIL success_alert: %b, required 1", Alert_MessageSuccessful);
    else passes++;
    tick;
    checks++;
    if ({TX_BUSY, Alert_MessageSuccessful} !== 2'b00)
      $display("FAIL success_idle: busy/alert=%b, required 00", {TX_BUSY, Alert_MessageSuccessful});
    else passes++;
  endtask

  task automatic test_retry_fail;
    nRetryCount = 3'd2;
    sb.push_back('{2, 3});
    send_req(3'd1, 3'd4, fr);
    phy_send; wait_gap(1'b0, CT + 2, "retry1_gap");
    phy_send; wait_gap(1'b0, CT + 2, "retry2_gap");
    phy_send; wait_gap(1'b1, CT + 1, "final_fail_gap");
    tick;
  endtask

  task automatic test_retry_success;
    nRetryCount = 3'd3;
    sb.push_back('{1, 2});
    send_req(3'd0, 3'd3, fr);
    phy_send; tick;
    GoodCRCResponse = 1'b1; RX_GOODCRC_MSG_ID = 3'd2; RX_BUF_FRAME_TYPE = 3'd0;
    tick;
    GoodCRCResponse = 1'b0;
    wait_gap(1'b0, 3, "msgid_mismatch_gap");
    phy_send; tick; tick;
    // GoodCRC lands on the last timeout cycle and must win over the timeout.
    GoodCRCResponse = 1'b1; RX_GOODCRC_MSG_ID = 3'd3; RX_BUF_FRAME_TYPE = 3'd0;
    tick;
    GoodCRCResponse = 1'b0;
    tick;
    checks++;
    if (Alert_MessageSuccessful !== 1'b1) $display("FAIL crc_at_timeout: success=%b, required 1", Alert_MessageSuccessful);
    else passes++;
    tick;
  endtask

  task automatic test_discard;
    nRetryCount = 3'd2;
    sb.push_back('{3, 1});
    send_req(3'd0, 3'd3, fr);
    phy_send; tick;
    RxMessageDiscard = 1'b1;
    TRANSMIT_VALID = 1'b1;
    tick;
    RxMessageDiscard = 1'b0;
    TRANSMIT_VALID = 1'b0;
    checks++;
    if (Alert_MessageDiscarded !== 1'b1) $display("FAIL discard_alert: %b, required 1", Alert_MessageDiscarded);
    else passes++;
    tick; tick;
    checks++;
    if (TX_BUSY !== 1'b0) $display("FAIL busy_request_ignored: TX_BUSY=%b, required 0", TX_BUSY);
    else passes++;
  endtask

  task automatic test_back_to_back;
    sb.push_back('{1, 1});
    send_req(3'd5, 3'd1, fr);
    RxMessageDiscard = 1'b1;
    phy_send;
    RxMessageDiscard = 1'b0;
    checks++;
    if (Alert_MessageSuccessful !== 1'b1 || TRANSMIT_DATA_OUTPUT !== fr)
      $display("FAIL hard_reset_1: success=%b data=%h, required 1 data=%h", Alert_MessageSuccessful, TRANSMIT_DATA_OUTPUT, fr);
    else passes++;
    tick;
    sb.push_back('{1, 1});
    send_req(3'd5, 3'd2, fr2);
    checks++;
    if (TX_BUSY !== 1'b1) $display("FAIL back_to_back_accept: TX_BUSY=%b, required 1", TX_BUSY);
    else passes++;
    phy_send;
    checks++;
    if (Alert_MessageSuccessful !== 1'b1 || TRANSMIT_DATA_OUTPUT !== fr2)
      $display("FAIL hard_reset_2: success=%b data=%h, required 1 data=%h", Alert_MessageSuccessful, TRANSMIT_DATA_OUTPUT, fr2);
    else passes++;
    tick;
  endtask

  task automatic test_sop6;
    send_req(3'd6, 3'd0, fr);
    repeat (4) tick;
    checks++;
    if ({TX_BUSY, TX_REQUEST} !== 2'b00) $display("FAIL sop6_ignored: busy/req=%b, required 00", {TX_BUSY, TX_REQUEST});
    else passes++;
  endtask

  task automatic test_reset_mid;
    nRetryCount = 3'd2;
    send_req(3'd0, 3'd3, fr);
    phy_send; tick;
    Reset = 1'b1;
    tick;
    checks++;
    if ({TX_BUSY, TX_REQUEST, Alert_MessageSuccessful, Alert_MessageFailed, Alert_MessageDiscarded} !== 5'b0 ||
        TRANSMIT_DATA_OUTPUT !== '0)
      $display("FAIL reset_mid: busy=%b req=%b alerts=%b data=%h, required all 0", TX_BUSY, TX_REQUEST,
               {Alert_MessageSuccessful, Alert_MessageFailed, Alert_MessageDiscarded}, TRANSMIT_DATA_OUTPUT);
    else passes++;
    Reset = 1'b0;
    tick;
  endtask

  task automatic test_tx_disable;
    TX_ENABLE = 1'b0;
    nRetryCount = 3'd2;
    sb.push_back('{2, 1});
    send_req(3'd0, 3'd3, fr);
    phy_send;
    wait_gap(1'b1, CT + 1, "disabled_fail_gap");
    TX_ENABLE = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_success;
    test_retry_fail;
    test_retry_success;
    test_discard;
    test_back_to_back;
    test_sop6;
    test_reset_mid;
    test_tx_disable;
    repeat (3) tick;
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
